bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin bus arbiter granting the shared system bus to one of four bus masters (CPU instruction port, CPU data port, DMA, debug) at a time. It sits in front of the bus address decoder and slave read-data multiplexer. It sequences ownership with a request/grant handshake, inserts a one-cycle turnaround between owners, and revokes the grant from a master whose transaction stalls past a programmable timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: consecutive not-ready cycles tolerated per owner before forced release; 0 disables the timeout.
- CNT_WIDTH, default 8: stall-counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_n_i  input  1  reset; synchronous, active-low.
- req_i  input  4  bus request, bit n from master n; level, held for the whole transaction.
- bus_rdy_i  input  1  ready from the slave read mux; sampled only while a master owns the bus.
- grnt_o  output  4  one-hot grant, bit n to master n; all zero when the bus is free.
- owner_o  output  2  index of the current owner; holds the last owner while the bus is free.
- busy_o  output  1  high while any grant is asserted.
- timeout_o  output  1  single-cycle pulse on forced release.

## Operation
- All outputs are registered.
- Reset values: grnt_o=0, owner_o=0, busy_o=0, timeout_o=0, priority pointer=0, mask=0, stall counter=0, state IDLE.
- State IDLE (grnt_o=0):
  - Eligible set = req_i & ~mask.
  - If the eligible set is non-empty, grant the first eligible master searching pointer, pointer+1, ... mod 4. Next state OWNED.
  - Otherwise stay in IDLE.
- State OWNED (grnt_o one-hot, busy_o=1):
  - If req_i[owner] is sampled low: release. Next state IDLE, pointer=owner+1 mod 4, counter cleared.
  - Else if timeout is enabled, bus_rdy_i is low and counter==TIMEOUT_CYCLES-1: forced release. Next state IDLE, timeout_o=1 for that one cycle, mask[owner] set, pointer=owner+1 mod 4, counter cleared.
  - Else: counter increments while bus_rdy_i is low and clears when bus_rdy_i is high. The counter saturates and never wraps.
- Mask:
  - mask[n] clears on any cycle where req_i[n] is sampled low.
  - A timed-out master must drop and re-raise its request before it can be granted again.
- Simultaneous events:
  - Owner request drop and timeout condition in the same cycle: normal release, no timeout pulse, no mask.
  - Mask set and clear for the same bit in the same cycle: set wins.
- A grant is never asserted to two masters, and never to a master whose req_i is low when sampled in IDLE.

## Timing
- Grant latency: request sampled in IDLE at edge k gives grnt_o valid in cycle k+1.
- Release: owner request sampled low at edge k gives grnt_o=0 in cycle k+1 (turnaround). The next grant is in cycle k+2 at the earliest.
- Back-to-back owners are therefore separated by exactly one idle cycle. Worst-case wait for a continuously requesting, unmasked master is 3 full ownerships plus 4 cycles.
- Timeout: counting starts in the first OWNED cycle. With TIMEOUT_CYCLES=T and bus_rdy_i continuously low, the grant is held T cycles. The cycle after that has grnt_o=0 and timeout_o=1.
- Synchronous reset mid-ownership: at the first edge with rst_n_i low, all outputs take their reset values. No turnaround pulse and no timeout_o are generated.

## Test plan
- Reset: drive req_i=4'b1111 with rst_n_i low for 3 cycles -> grnt_o=0, busy_o=0, timeout_o=0, owner_o=0 throughout. Release reset -> grnt_o=4'b0001 one cycle after the first sampled edge.
- Single master: req_i=4'b0100 from cycle 0, drop at cycle 5 -> grnt_o=4'b0100 in cycles 1..5, owner_o=2, busy_o=1. grnt_o=0 from cycle 6.
- Round robin: all masters request continuously; each owner drops its request for one cycle after 2 granted cycles, then re-raises it -> grant order 0,1,2,3,0. Each grant lasts 2 cycles with exactly one idle cycle between owners.
- Timeout: TIMEOUT_CYCLES=4, bus_rdy_i=0; m1 requests, then m3 requests while m1 holds -> grnt_o=4'b0010 for 4 cycles. Next cycle: grnt_o=0, timeout_o=1. Following cycle: grnt_o=4'b1000. m1 is not regranted until its req_i goes low then high.
- Ready resets stall count: TIMEOUT_CYCLES=4, m0 owns, bus_rdy_i high every 3rd cycle for 20 cycles -> timeout_o never asserts and grnt_o stays 4'b0001.
- Simultaneous events and reset: TIMEOUT_CYCLES=4, m2 drops its request exactly in the 4th stall cycle -> no timeout_o, m2 not masked. Separately, assert rst_n_i low during m3 ownership -> grnt_o=0 and pointer=0 next cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with a one-cycle turnaround between
// owners and a programmable stall timeout that forcibly revokes a grant.

module bus_arbiter_mask_lane (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req,
  input  logic set,
  output logic masked
);
  // Set has priority so a timed-out master can never slip back in on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  masked <= 1'b0;
    else if (set)  masked <= 1'b1;
    else if (!req) masked <= 1'b0;
  end
endmodule

module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] req_i,
  input  logic       bus_rdy_i,
  output logic [3:0] grnt_o,
  output logic [1:0] owner_o,
  output logic       busy_o,
  output logic       timeout_o
);
  localparam int NUM_LANES = 4;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             ptr, ptr_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [NUM_LANES-1:0]   mask, mask_set, eligible;
  logic [NUM_LANES-1:0]   grnt_nxt;
  logic [1:0]             owner_nxt, pick_idx;
  logic                   busy_nxt, timeout_nxt, pick_vld;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    bus_arbiter_mask_lane u_lane (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .req    (req_i[n]),
      .set    (mask_set[n]),
      .masked (mask[n])
    );
  end

  assign eligible = req_i & ~mask;

  // First eligible master at or after the priority pointer, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick_idx = ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ptr + 2'(i);
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grnt_nxt    = grnt_o;
    owner_nxt   = owner_o;
    busy_nxt    = busy_o;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    mask_set    = '0;
    case (state)
      IDLE: begin
        grnt_nxt = '0;
        busy_nxt = 1'b0;
        if (pick_vld) begin
          state_nxt = OWNED;
          grnt_nxt  = NUM_LANES'(1) << pick_idx;
          owner_nxt = pick_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      OWNED: begin
        if (!req_i[owner_o]) begin
          state_nxt = IDLE;
          grnt_nxt  = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = owner_o + 2'd1;
          cnt_nxt   = '0;
        end else if (TO_EN && !bus_rdy_i && cnt == TO_LAST) begin
          state_nxt         = IDLE;
          grnt_nxt          = '0;
          busy_nxt          = 1'b0;
          timeout_nxt       = 1'b1;
          mask_set[owner_o] = 1'b1;
          ptr_nxt           = owner_o + 2'd1;
          cnt_nxt           = '0;
        end else if (bus_rdy_i) begin
          cnt_nxt = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grnt_o    <= '0;
      owner_o   <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grnt_o    <= grnt_nxt;
      owner_o   <= owner_nxt;
      busy_o    <= busy_nxt;
      timeout_o <= timeout_nxt;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them.

module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rdy;
  logic [3:0] grnt;
  logic [1:0] owner;
  logic       busy, tmo;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  typedef struct {
    int         due;
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       t;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;

  bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .req_i    (req),
    .bus_rdy_i(rdy),
    .grnt_o   (grnt),
    .owner_o  (owner),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_total++;
      if (e.due != cyc || grnt !== e.g || owner !== e.o || busy !== e.b || tmo !== e.t)
        $display("FAIL %s cyc=%0d due=%0d: got grnt=%b owner=%0d busy=%b timeout=%b, need grnt=%b owner=%0d busy=%b timeout=%b",
                 e.nm, cyc, e.due, grnt, owner, busy, tmo, e.g, e.o, e.b, e.t);
      else
        n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for the current cycle (after the edge just taken).
  task automatic chk(input logic [3:0] g, input logic [1:0] o, input logic b,
                     input logic t, input string nm);
    exp_t x;
    x.due = cyc; x.g = g; x.o = o; x.b = b; x.t = t; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rdy = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk(4'b0000, 2'd0, 1'b0, 1'b0, "post_reset_idle");
  endtask

  initial begin
    // Reset held with all masters requesting.
    rst_n = 1'b0; req = 4'b1111; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(4'b0000, 2'd0, 1'b0, 1'b0, "reset_hold");
    end
    rst_n = 1'b1;
    tick();
    chk(4'b0001, 2'd0, 1'b1, 1'b0, "reset_release_grant");

    // Single master m2.
    do_reset();
    req = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk(4'b0100, 2'd2, 1'b1, 1'b0, "single_grant");
    end
    req = 4'b0000;
    tick(); chk(4'b0000, 2'd2, 1'b0, 1'b0, "single_release");
    tick(); chk(4'b0000, 2'd2, 1'b0, 1'b0, "single_idle");

    // Round robin 0,1,2,3,0 with one turnaround cycle between owners.
    do_reset();
    req = 4'b1111;
    tick();
    for (int m = 0; m < 4; m++) begin
      chk(4'b0001 << m, 2'(m), 1'b1, 1'b0, "rr_grant_a");
      tick();
      chk(4'b0001 << m, 2'(m), 1'b1, 1'b0, "rr_grant_b");
      req[m] = 1'b0;
      tick();
      chk(4'b0000, 2'(m), 1'b0, 1'b0, "rr_turnaround");
      req[m] = 1'b1;
      tick();
    end
    chk(4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap_m0");
    req = 4'b0000;
    tick();

    // Timeout of m1 while m3 waits; m1 masked until it drops its request.
    do_reset();
    rdy = 1'b0;
    req = 4'b0010;
    tick();
    chk(4'b0010, 2'd1, 1'b1, 1'b0, "to_grant_m1");
    req = 4'b1010;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk(4'b0010, 2'd1, 1'b1, 1'b0, "to_hold_m1");
    end
    tick(); chk(4'b0000, 2'd1, 1'b0, 1'b1, "to_pulse");
    tick(); chk(4'b1000, 2'd3, 1'b1, 1'b0, "to_grant_m3");
    req = 4'b0010;
    tick(); chk(4'b0000, 2'd3, 1'b0, 1'b0, "to_m3_release");
    tick(); chk(4'b0000, 2'd3, 1'b0, 1'b0, "to_m1_masked");
    req = 4'b0000;
    tick(); chk(4'b0000, 2'd3, 1'b0, 1'b0, "to_m1_dropped");
    req = 4'b0010;
    tick(); chk(4'b0010, 2'd1, 1'b1, 1'b0, "to_m1_regrant");
    req = 4'b0000; rdy = 1'b1;
    tick(); chk(4'b0000, 2'd1, 1'b0, 1'b0, "to_m1_release");

    // Ready every third cycle keeps clearing the stall count.
    do_reset();
    req = 4'b0001; rdy = 1'b0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      chk(4'b0001, 2'd0, 1'b1, 1'b0, "rdy_no_timeout");
      rdy = (i % 3 == 0);
      tick();
    end
    chk(4'b0001, 2'd0, 1'b1, 1'b0, "rdy_still_owned");
    req = 4'b0000; rdy = 1'b1;
    tick(); chk(4'b0000, 2'd0, 1'b0, 1'b0, "rdy_release");

    // Request drop coincides with the timeout condition: plain release.
    do_reset();
    rdy = 1'b0;
    req = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk(4'b0100, 2'd2, 1'b1, 1'b0, "sim_hold_m2");
    end
    req = 4'b0000;
    tick(); chk(4'b0000, 2'd2, 1'b0, 1'b0, "sim_no_pulse");
    req = 4'b0100;
    tick(); chk(4'b0100, 2'd2, 1'b1, 1'b0, "sim_m2_unmasked");
    req = 4'b0000; rdy = 1'b1;
    tick(); chk(4'b0000, 2'd2, 1'b0, 1'b0, "sim_release");

    // Reset mid-ownership of m3 after the pointer has moved to 2.
    do_reset();
    req = 4'b0010;
    tick(); chk(4'b0010, 2'd1, 1'b1, 1'b0, "rst_m1_grant");
    req = 4'b0000;
    tick(); chk(4'b0000, 2'd1, 1'b0, 1'b0, "rst_m1_release");
    req = 4'b1000;
    tick(); chk(4'b1000, 2'd3, 1'b1, 1'b0, "rst_m3_grant");
    rst_n = 1'b0;
    tick(); chk(4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid_own");
    rst_n = 1'b1; req = 4'b1001;
    tick(); chk(4'b0001, 2'd0, 1'b1, 1'b0, "rst_ptr_zero");
    req = 4'b0000;
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, need 0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
